word_exp_r26: RTL

//  Converts an operand into the Montgomery domain: x_out = x_in * 2^(R*NW) mod q, R = 26.

---
 rtl/word_exp_r26_if.sv | 28 ++
 rtl/word_exp_r26.sv | 116 +++++++++++
 2 files changed

// File: rtl/word_exp_r26_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_exp_r26_if                                                          |
// | Operand/result handshake bundle for the Montgomery-domain entry stage.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface word_exp_r26_if #(
    parameter int Q_LEN = 64
);
    logic [Q_LEN-1:0] q;
    logic             in_valid;
    logic             in_ready;
    logic [Q_LEN-1:0] x_in;
    logic             out_valid;
    logic             out_ready;
    logic [Q_LEN-1:0] x_out;

    modport master (
        output q, in_valid, x_in, out_ready,
        input  in_ready, out_valid, x_out
    );

    modport slave (
        input  q, in_valid, x_in, out_ready,
        output in_ready, out_valid, x_out
    );
endinterface
`default_nettype wire

// File: rtl/word_exp_r26.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_exp_r26                                                             |
// | x_out = x_in * 2^(26*NW) mod q by iterative shift / conditional subtract. |
// | Option macro WORD_EXP_2BIT_EN: retire two bits per RUN cycle.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module word_exp_r26 #(
    parameter int Q_LEN = 64,
    parameter int NW    = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    word_exp_r26_if.slave      bus
);
    localparam int c_R     = 26;
    localparam int c_SHIFT = c_R * NW;
`ifdef WORD_EXP_2BIT_EN
    localparam int c_STEPS = c_SHIFT / 2;
`else
    localparam int c_STEPS = c_SHIFT;
`endif
    localparam int            c_CW       = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [Q_LEN-1:0]  acc_q, acc_d;
    logic [Q_LEN-1:0]  q_q, q_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;
    logic [Q_LEN-1:0]  w_step;

`ifdef WORD_EXP_2BIT_EN
    // acc < q, so the shifted value is below 4q and k never exceeds 3.
    logic [Q_LEN+1:0] w_t, w_q1, w_q2, w_q3;
    assign w_t  = {acc_q, 2'b00};
    assign w_q1 = {2'b00, q_q};
    assign w_q2 = {1'b0, q_q, 1'b0};
    assign w_q3 = w_q1 + w_q2;

    always_comb begin
        w_step = w_t[Q_LEN-1:0];
        if (w_t >= w_q3)
            w_step = w_t[Q_LEN-1:0] - w_q3[Q_LEN-1:0];
        else if (w_t >= w_q2)
            w_step = w_t[Q_LEN-1:0] - w_q2[Q_LEN-1:0];
        else if (w_t >= w_q1)
            w_step = w_t[Q_LEN-1:0] - q_q;
    end
`else
    logic [Q_LEN:0] w_t, w_q1;
    assign w_t  = {acc_q, 1'b0};
    assign w_q1 = {1'b0, q_q};

    always_comb begin
        w_step = w_t[Q_LEN-1:0];
        if (w_t >= w_q1)
            w_step = w_t[Q_LEN-1:0] - q_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // MSB of q is set, so x_in < 2q and one subtraction fully reduces it.
                    q_d     = bus.q;
                    acc_d   = (bus.x_in >= bus.q) ? (bus.x_in - bus.q) : bus.x_in;
                    cnt_d   = c_CNT_LAST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = w_step;
                if (cnt_q == '0)
                    state_d = S_DONE;
                else
                    cnt_d = cnt_q - c_CW'(1);
            end
            S_DONE: begin
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.x_out     = acc_q;

endmodule
`default_nettype wire
